// File: rtl/qft3_readout_pkg.sv
// Shared constants for the 3-qubit QFT readout stage, kept in step with the QFT top.
// Basis index type and probability widths live here so every stage agrees on them.
package qft3_readout_pkg;

  localparam int TOTAL_WIDTH  = 8;
  localparam int FRAC_WIDTH   = 4;
  localparam int QFT3_LATENCY = 19;
  localparam int NUM_BASIS    = 8;
  localparam int PROB_WIDTH   = 2 * TOTAL_WIDTH + 1;
  localparam int ONE_SQ       = 1 << (2 * FRAC_WIDTH);

  typedef logic [2:0] basis_idx_t;

endpackage

// File: rtl/qft3_readout_prob_cmp_sel.sv
// Registered compare-select of two (index, probability) pairs.
// The lo_* pair must carry the lower basis index; it wins on equal probabilities.
module prob_cmp_sel
  import qft3_readout_pkg::*;
#(
  parameter int PW = PROB_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  basis_idx_t    lo_idx,
  input  logic [PW-1:0] lo_prob,
  input  basis_idx_t    hi_idx,
  input  logic [PW-1:0] hi_prob,
  output basis_idx_t    sel_idx,
  output logic [PW-1:0] sel_prob
);

  // Strict > keeps the lower index on a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_idx  <= '0;
      sel_prob <= '0;
    end else if (en) begin
      if (hi_prob > lo_prob) begin
        sel_idx  <= hi_idx;
        sel_prob <= hi_prob;
      end else begin
        sel_idx  <= lo_idx;
        sel_prob <= lo_prob;
      end
    end
  end

endmodule

// File: rtl/qft3_readout.sv
// Readout stage after the 3-qubit QFT: |a|^2 per basis state, argmax, total and norm check.
// The QFT has no valid output, so in_valid is delayed by the QFT latency to qualify its results.
module qft3_readout
  import qft3_readout_pkg::*;
#(
  parameter int W        = TOTAL_WIDTH,
  parameter int FRAC     = FRAC_WIDTH,
  parameter int QFT_LAT  = QFT3_LATENCY,
  parameter int NORM_TOL = 64,
  parameter int CNT_W    = 16,
  localparam int PW      = 2 * W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [8*W-1:0]       amp_r,
  input  logic [8*W-1:0]       amp_i,
  output logic [8*PW-1:0]      prob,
  output basis_idx_t           max_idx,
  output logic [PW-1:0]        max_prob,
  output logic [PW+2:0]        prob_sum,
  output logic                 norm_err,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam logic [PW+2:0]    ONE      = (PW+3)'(1) << (2 * FRAC);
  localparam logic [PW+2:0]    TOL      = (PW+3)'(NORM_TOL);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [2*W-1:0] square(input logic signed [W-1:0] a);
    logic signed [2*W-1:0] p;
    p = a * a;
    return $unsigned(p);
  endfunction

  logic [QFT_LAT-1:0] vsr;
  logic               v0, v1, v2, v3, v4;

  logic [2*W-1:0]     sq_r  [NUM_BASIS];
  logic [2*W-1:0]     sq_i  [NUM_BASIS];
  logic [PW-1:0]      prob2 [NUM_BASIS];
  logic [PW-1:0]      p3_prob [NUM_BASIS];
  logic [PW-1:0]      p4_prob [NUM_BASIS];
  logic [PW:0]        s3 [4];
  logic [PW+1:0]      s4 [2];

  basis_idx_t         idx3 [4];
  logic [PW-1:0]      max3 [4];
  basis_idx_t         idx4 [2];
  logic [PW-1:0]      max4 [2];

  logic [PW+2:0]      sum5;
  logic [PW+2:0]      diff5;

  assign v0 = vsr[QFT_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr <= '0;
    end else begin
      vsr <= {vsr[QFT_LAT-2:0], in_valid};
    end
  end

  // P1/P2 load every cycle; the travelling valid bit says which cycles matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      for (int k = 0; k < NUM_BASIS; k++) begin
        sq_r[k]  <= '0;
        sq_i[k]  <= '0;
        prob2[k] <= '0;
      end
    end else begin
      v1 <= v0;
      v2 <= v1;
      for (int k = 0; k < NUM_BASIS; k++) begin
        sq_r[k]  <= square(amp_r[k*W +: W]);
        sq_i[k]  <= square(amp_i[k*W +: W]);
        prob2[k] <= PW'(sq_r[k]) + PW'(sq_i[k]);
      end
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_p3
    prob_cmp_sel #(.PW(PW)) u_sel (
      .clk      (clk),
      .rst      (rst),
      .en       (1'b1),
      .lo_idx   (basis_idx_t'(2*j)),
      .lo_prob  (prob2[2*j]),
      .hi_idx   (basis_idx_t'(2*j+1)),
      .hi_prob  (prob2[2*j+1]),
      .sel_idx  (idx3[j]),
      .sel_prob (max3[j])
    );
  end

  for (genvar j = 0; j < 2; j++) begin : g_p4
    prob_cmp_sel #(.PW(PW)) u_sel (
      .clk      (clk),
      .rst      (rst),
      .en       (1'b1),
      .lo_idx   (idx3[2*j]),
      .lo_prob  (max3[2*j]),
      .hi_idx   (idx3[2*j+1]),
      .hi_prob  (max3[2*j+1]),
      .sel_idx  (idx4[j]),
      .sel_prob (max4[j])
    );
  end

  // Final compare is gated so max_idx/max_prob hold with the other results.
  prob_cmp_sel #(.PW(PW)) u_p5_sel (
    .clk      (clk),
    .rst      (rst),
    .en       (v4),
    .lo_idx   (idx4[0]),
    .lo_prob  (max4[0]),
    .hi_idx   (idx4[1]),
    .hi_prob  (max4[1]),
    .sel_idx  (max_idx),
    .sel_prob (max_prob)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0;
      v4 <= 1'b0;
      for (int k = 0; k < NUM_BASIS; k++) begin
        p3_prob[k] <= '0;
        p4_prob[k] <= '0;
      end
      for (int j = 0; j < 4; j++) s3[j] <= '0;
      for (int j = 0; j < 2; j++) s4[j] <= '0;
    end else begin
      v3 <= v2;
      v4 <= v3;
      for (int k = 0; k < NUM_BASIS; k++) begin
        p3_prob[k] <= prob2[k];
        p4_prob[k] <= p3_prob[k];
      end
      for (int j = 0; j < 4; j++) s3[j] <= (PW+1)'(prob2[2*j]) + (PW+1)'(prob2[2*j+1]);
      for (int j = 0; j < 2; j++) s4[j] <= (PW+2)'(s3[2*j]) + (PW+2)'(s3[2*j+1]);
    end
  end

  always_comb begin
    sum5  = (PW+3)'(s4[0]) + (PW+3)'(s4[1]);
    diff5 = (sum5 >= ONE) ? (sum5 - ONE) : (ONE - sum5);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prob      <= '0;
      prob_sum  <= '0;
      norm_err  <= 1'b0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_valid <= v4;
      if (v4) begin
        for (int k = 0; k < NUM_BASIS; k++) prob[k*PW +: PW] <= p4_prob[k];
        prob_sum <= sum5;
        norm_err <= (diff5 > TOL);
        if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/qft3_readout.md
Name: qft3_readout

Overview:
- Downstream consumer of the 3-qubit pipelined QFT top.
- Takes the eight complex output amplitudes and computes each basis-state probability |a|^2.
- Finds the most probable basis index and checks the total probability against 1.0.
- Re-creates the QFT's missing valid strobe with a latency-matched delay line, so the host can sample results with a qualified strobe.

Parameters:
- W, `TOTAL_WIDTH: signed amplitude width, same as the QFT datapath.
- FRAC, 4: fractional bits of amplitudes; 1.0 = 2^FRAC = 16.
- QFT_LAT, 19: QFT input-to-output latency in cycles (6 stages x 3 + swap 1).
- NORM_TOL, 64: allowed |sum(prob) - 2^(2*FRAC)| before flagging, in prob LSBs.
- CNT_W, 16: width of the result frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pulses in the same cycle a state vector is presented to the QFT inputs.
- amp_r  in  8*W  QFT real outputs, packed; slice k = basis index k (f000 = slice 0 ... f111 = slice 7).
- amp_i  in  8*W  QFT imaginary outputs, same packing.
- prob  out  8*PW  per-index probability, PW = 2*W+1, unsigned, slice k = index k.
- max_idx  out  3  index of the largest probability.
- max_prob  out  PW  value of that probability.
- prob_sum  out  PW+3  sum of all eight probabilities.
- norm_err  out  1  |prob_sum - 2^(2*FRAC)| > NORM_TOL.
- out_valid  out  1  one-cycle strobe qualifying all result outputs.
- frame_cnt  out  CNT_W  number of out_valid pulses since reset, saturating.

Behaviour:
- Reset (async, rst=1):
  - All valid bits, out_valid, frame_cnt, prob, max_idx, max_prob, prob_sum and norm_err clear to 0 immediately.
  - In-flight frames are discarded: no out_valid for any in_valid seen before reset deasserts.
- Valid tracking:
  - A QFT_LAT-deep shift register delays in_valid to give v0.
  - v0 marks the cycle amp_r/amp_i hold a valid QFT result.
  - Back-to-back in_valid is legal, one frame per cycle, no stalls, no backpressure.
- Pipeline, one register per stage; the valid bit travels alongside:
  - P1: re^2 and im^2 per index; signed W x W gives an unsigned 2W product.
  - P2: prob_k = re^2 + im^2, PW bits. No overflow is possible: max is 2*(2^(W-1))^2.
  - P3: compare-select 8->4 on pairs (0,1) (2,3) (4,5) (6,7); partial sums of pairs.
  - P4: 4->2 compare; partial sums.
  - P5: 2->1 compare; final sum; norm check; all outputs registered.
- Latency:
  - in_valid at cycle t -> out_valid at t + QFT_LAT + 5 (default t+24).
  - Equivalently, QFT output cycle + 5.
- Tie-break: at every compare, the lower index wins when probabilities are equal (use >, not >=, for the upper index).
- prob is forwarded from P2 through matching delay registers, so all outputs belong to the same frame.
- Result outputs hold their last value while out_valid=0. Data registers may load every cycle; only out_valid qualifies them.
- frame_cnt increments by 1 on each out_valid and saturates at 2^CNT_W-1.
- norm_err:
  - Compares prob_sum against the constant ONE_SQ = 1 << (2*FRAC) = 256.
  - Uses an unsigned absolute difference and a strict > NORM_TOL.
- All arithmetic is unsigned after squaring. No rounding or truncation inside the block.

Decomposition:
- Shared header (extends fixed_point_params.vh):
  - QFT3_LATENCY = 19, so this block and the QFT top agree.
  - PROB_WIDTH = 2*`TOTAL_WIDTH+1.
  - ONE_SQ.
- One natural sub-module: prob_cmp_sel.
  - Registered compare-select of two (index, prob) pairs with lower-index-wins.
  - Instantiated 4+2+1 times across P3-P5.

Test Plan (W=8, FRAC=4; drive amp inputs directly, aligned QFT_LAT cycles after in_valid):
- Single frame: in_valid at cycle 0; at cycle 19 all amps r=6, i=0 -> at cycle 24: out_valid=1, every prob=36, max_idx=0, max_prob=36, prob_sum=288, norm_err=0, frame_cnt=1.
- Sparse: index 5 = (-8,12), others 0 -> prob[5]=208, max_idx=5, max_prob=208, prob_sum=208, norm_err=0 (|208-256|=48 <= 64).
- All zero amps -> max_idx=0, prob_sum=0, norm_err=1. Ties among equal nonzero probs at indices 3 and 6 -> max_idx=3.
- Extremes: index 7 = (-128,-128) -> prob[7]=32768, max_idx=7, with no wrap in any sum.
- Streaming: in_valid high for cycles 0-2 with distinct vectors -> out_valid high for cycles 24-26, results in order, frame_cnt=3.
- Reset: in_valid at cycle 0, rst pulse at cycle 10 -> outputs 0 immediately, no out_valid at cycle 24, frame_cnt=0.
